// File: rtl/bit_serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package adder_defs;

   localparam int ADD_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/bit_serial_adder_fa_cell.sv
// One-bit full adder; the only arithmetic in the bit-serial adder.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/bit_serial_adder.sv
// W-bit adder that streams operands LSB-first through a single full-adder cell,
// one bit per clock, behind valid/ready handshakes on both sides.
module bit_serial_adder
   import adder_defs::*;
#(
   parameter int W     = ADD_W,
   parameter int CNT_W = ($clog2(W) > 0) ? $clog2(W) : 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] sum,
   output logic         cout,
   output logic         busy
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

   state_t           state, state_nxt;
   logic [W-1:0]     a_sr, b_sr, sum_sr, sum_nxt;
   logic             c_q;
   logic [CNT_W-1:0] cnt;
   logic             s, co;

   fa_cell u_fa (
      .a  (a_sr[0]),
      .b  (b_sr[0]),
      .ci (c_q),
      .s  (s),
      .co (co)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (in_valid)        state_nxt = ST_RUN;
         ST_RUN:  if (cnt == CNT_LAST) state_nxt = ST_DONE;
         ST_DONE: if (out_ready)       state_nxt = ST_IDLE;
         default:                      state_nxt = ST_IDLE;
      endcase
      // New sum bit enters at the MSB so that after W shifts bit 0 sits at the LSB.
      sum_nxt        = sum_sr >> 1;
      sum_nxt[W-1]   = s;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr   <= '0;
         b_sr   <= '0;
         sum_sr <= '0;
         c_q    <= 1'b0;
         cnt    <= '0;
      end else begin
         case (state)
            ST_IDLE: if (in_valid) begin
               a_sr   <= a;
               b_sr   <= b;
               c_q    <= cin;
               sum_sr <= '0;
               cnt    <= '0;
            end
            ST_RUN: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               sum_sr <= sum_nxt;
               c_q    <= co;
               cnt    <= cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == ST_IDLE);
   assign busy      = (state == ST_RUN);
   assign out_valid = (state == ST_DONE);
   assign sum       = sum_sr;
   assign cout      = c_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed + randomized bench for bit_serial_adder; W=4 and W=1 builds checked against a+b+cin.
module tb_bit_serial_adder;
   import adder_defs::*;

   localparam int W = ADD_W;

   logic         clk, rst_n;
   logic         in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
   logic [W-1:0] a, b, sum;
   logic         in_valid1, in_ready1, a1, b1, cin1, out_valid1, out_ready1, sum1, cout1, busy1;

   int checks = 0;
   int errors = 0;

   bit_serial_adder #(.W(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .busy(busy)
   );

   bit_serial_adder #(.W(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
      .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
      .sum(sum1), .cout(cout1), .busy(busy1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One W-bit operation; hold>0 keeps out_ready low that many cycles in DONE
   // while pulsing in_valid with different operands.
   task automatic op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc, input int hold);
      int           n;
      int           total;
      logic [W-1:0] exp_sum;
      logic         exp_cout;
      total    = int'(oa) + int'(ob) + int'(oc);
      exp_sum  = W'(total);
      exp_cout = total[W];
      a = oa; b = ob; cin = oc; in_valid = 1'b1; out_ready = (hold == 0);
      chk("in_ready_idle", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 40) begin
         chk("in_ready_run", 32'(in_ready), 32'd0);
         chk("busy_run", 32'(busy), 32'd1);
         @(posedge clk); #1;
         n++;
      end
      chk("latency", 32'(n), 32'(W));
      chk("sum", 32'(sum), 32'(exp_sum));
      chk("cout", 32'(cout), 32'(exp_cout));
      for (int i = 0; i < hold; i++) begin
         a = ~oa; b = oa ^ ob; cin = ~oc; in_valid = i[0];
         @(posedge clk); #1;
         chk("hold_valid", 32'(out_valid), 32'd1);
         chk("hold_in_ready", 32'(in_ready), 32'd0);
         chk("hold_sum", 32'(sum), 32'(exp_sum));
         chk("hold_cout", 32'(cout), 32'(exp_cout));
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      chk("consumed_valid", 32'(out_valid), 32'd0);
      chk("consumed_in_ready", 32'(in_ready), 32'd1);
      chk("kept_sum", 32'(sum), 32'(exp_sum));
      chk("kept_cout", 32'(cout), 32'(exp_cout));
   endtask

   task automatic op1(input logic oa, input logic ob, input logic oc);
      int n;
      int total;
      total = int'(oa) + int'(ob) + int'(oc);
      a1 = oa; b1 = ob; cin1 = oc; in_valid1 = 1'b1;
      chk("w1_in_ready", 32'(in_ready1), 32'd1);
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      n = 0;
      while (!out_valid1 && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      chk("w1_latency", 32'(n), 32'd1);
      chk("w1_sum", 32'(sum1), 32'(total % 2));
      chk("w1_cout", 32'(cout1), 32'(total / 2));
      @(posedge clk); #1;
      chk("w1_consumed", 32'(out_valid1), 32'd0);
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      int           n;
      rst_n = 1'b0;
      in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
      in_valid1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0; out_ready1 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;

      op(0, 0, 0, 0);
      op(15, 1, 0, 0);
      op(5, 10, 1, 0);
      op(3, 4, 0, 0);

      for (int i = 0; i < 512; i++)
         op(W'(i), W'(i >> 4), i[8], 0);

      op(7, 6, 1, 5);

      for (int i = 0; i < 100; i++)
         op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

      // Abort during the second RUN cycle.
      a = 9; b = 9; cin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("pre_abort_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_valid", 32'(out_valid), 32'd0);
      chk("abort_sum", 32'(sum), 32'd0);
      chk("abort_cout", 32'(cout), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (out_valid) n++;
      end
      chk("abort_no_valid", 32'(n), 32'd0);
      chk("abort_idle", 32'(in_ready), 32'd1);
      op(2, 3, 0, 0);

      for (int i = 0; i < 8; i++)
         op1(i[0], i[1], i[2]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
